// File: rtl/mfcc_preemph_framer.sv
// Pre-emphasis filter and overlapping frame buffer feeding the MFCC stage.
// Define MFCC_PREEMPH_EN to enable the y = x - xp + (xp >>> 5) filter; otherwise y = x.
module mfcc_preemph_framer #(
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned HOP       = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] frm_data,
   output logic        frm_valid,
   input  logic        frm_ready,
   output logic        frm_start,
   output logic        frm_last,
   output logic [15:0] frame_count
);

   localparam int unsigned AW = $clog2(FRAME_LEN);
   localparam int unsigned CW = AW + 1;

   typedef enum logic {StFill, StEmit} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, base_q, rd_addr;
   logic [CW-1:0]     fill_cnt_q, rd_cnt_q, fill_target;
   logic              first_q, lead_q;
   logic [15:0]       frame_count_q;
   logic [15:0]       out_data_q;
   logic              out_valid_q, out_start_q, out_last_q;
   logic [15:0]       mem [FRAME_LEN];

   logic              accept, fill_done, xfer, xfer_last, load;
   logic signed [8:0] x;
   logic signed [15:0] y;

   assign in_ready    = (state_q == StFill) && !rst;
   assign frm_data    = out_data_q;
   assign frm_valid   = out_valid_q;
   assign frm_start   = out_start_q;
   assign frm_last    = out_last_q;
   assign frame_count = frame_count_q;

   // in_data - 128 is the offset-binary sample with its MSB flipped
   assign x = {~in_data[7], ~in_data[7], in_data[6:0]};

`ifdef MFCC_PREEMPH_EN
   logic signed [8:0]  xp_q;
   logic signed [15:0] x_ext, xp_ext;

   always_comb begin
      x_ext  = {{7{x[8]}}, x};
      xp_ext = {{7{xp_q[8]}}, xp_q};
      y      = x_ext - xp_ext + (xp_ext >>> 5);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xp_q <= '0;
      end else if (accept) begin
         xp_q <= x;
      end
   end
`else
   assign y = {{7{x[8]}}, x};
`endif

   always_comb begin
      accept      = in_valid && in_ready;
      fill_target = first_q ? CW'(FRAME_LEN) : CW'(HOP);
      fill_done   = accept && ((fill_cnt_q + CW'(1)) == fill_target);
      xfer        = out_valid_q && frm_ready;
      xfer_last   = xfer && out_last_q;
      // lead_q spends one cycle after the last write so data appears two edges later
      load        = (state_q == StEmit) && !lead_q && (rd_cnt_q != CW'(FRAME_LEN)) &&
                    (!out_valid_q || frm_ready);
      rd_addr     = base_q + rd_cnt_q[AW-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill: if (fill_done) state_d = StEmit;
         StEmit: if (xfer_last) state_d = StFill;
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFill;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_q] <= y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         base_q        <= '0;
         fill_cnt_q    <= '0;
         rd_cnt_q      <= '0;
         first_q       <= 1'b1;
         lead_q        <= 1'b0;
         frame_count_q <= '0;
      end else begin
         lead_q <= fill_done;
         if (accept) begin
            wr_ptr_q   <= wr_ptr_q + AW'(1);
            fill_cnt_q <= fill_done ? '0 : fill_cnt_q + CW'(1);
         end
         if (fill_done) begin
            first_q  <= 1'b0;
            rd_cnt_q <= '0;
         end else if (load) begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
         end
         if (xfer_last) begin
            base_q        <= base_q + AW'(HOP);
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_start_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (load) begin
         out_data_q  <= mem[rd_addr];
         out_valid_q <= 1'b1;
         out_start_q <= (rd_cnt_q == '0);
         out_last_q  <= (rd_cnt_q == CW'(FRAME_LEN - 1));
      end else if (xfer) begin
         out_valid_q <= 1'b0;
         out_start_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mfcc_preemph_framer.sv
// Self-checking bench for mfcc_preemph_framer: stream-level reference model plus
// literal expectations for the directed vectors.
module tb_mfcc_preemph_framer;

   localparam int FL  = 256;
   localparam int HOP = 128;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] frm_data;
   logic        frm_valid;
   logic        frm_ready = 1'b1;
   logic        frm_start;
   logic        frm_last;
   logic [15:0] frame_count;

   mfcc_preemph_framer #(.FRAME_LEN(FL), .HOP(HOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .frm_data   (frm_data),
      .frm_valid  (frm_valid),
      .frm_ready  (frm_ready),
      .frm_start  (frm_start),
      .frm_last   (frm_last),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: every accepted sample's y; frame k covers stream [k*HOP, k*HOP+FL)
   int          ys[$];
   int          out_log[$];
   int          xp_m = 0;
   int          n_acc = 0;
   int          k_frm = 0;
   int          idx = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic        prev_valid = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_start = 1'b0;
   logic        prev_last = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_y(input int din);
      int x;
`ifdef MFCC_PREEMPH_EN
      int fl;
`endif
      x = din - 128;
`ifdef MFCC_PREEMPH_EN
      fl = (xp_m - (((xp_m % 32) + 32) % 32)) / 32;
      return x - xp_m + fl;
`else
      return x;
`endif
   endfunction

   always @(negedge clk) begin
      int need;
      int pos;
      int exp;
      cyc++;
      if (rst) begin
         check("rst_frm_valid", int'(frm_valid), 0);
         check("rst_frm_start", int'(frm_start), 0);
         check("rst_frm_last", int'(frm_last), 0);
         check("rst_frm_data", int'(frm_data), 0);
         check("rst_in_ready", int'(in_ready), 0);
         check("rst_frame_count", int'(frame_count), 0);
         ys.delete();
         xp_m = 0;
         n_acc = 0;
         k_frm = 0;
         idx = 0;
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end else begin
         need = FL + k_frm * HOP;
         check("in_ready", int'(in_ready), int'(n_acc < need));
         if (frm_valid) begin
            if (n_acc < need) check("valid_before_frame_complete", 1, 0);
            if (!prev_valid) check("first_valid_latency", cyc - acc_cyc, 3);
            pos = k_frm * HOP + idx;
            exp = (pos < ys.size()) ? ys[pos] : -99999;
            check("frm_data", int'($signed(frm_data)), exp);
            check("frm_start", int'(frm_start), int'(idx == 0));
            check("frm_last", int'(frm_last), int'(idx == FL - 1));
         end
         if (prev_stall) begin
            check("stall_valid_held", int'(frm_valid), 1);
            check("stall_data_held", int'(frm_data), int'(prev_data));
            check("stall_start_held", int'(frm_start), int'(prev_start));
            check("stall_last_held", int'(frm_last), int'(prev_last));
         end
         check("frame_count", int'(frame_count), k_frm & 32'hFFFF);
         // Advance the model by what the coming edge transfers
         if (in_valid && (n_acc < need)) begin
            ys.push_back(model_y(int'(in_data)));
            xp_m = int'(in_data) - 128;
            n_acc++;
            acc_cyc = cyc;
         end
         if (frm_valid && frm_ready) begin
            out_log.push_back(int'($signed(frm_data)));
            idx++;
            if (idx == FL) begin
               idx = 0;
               k_frm++;
            end
         end
         prev_valid = frm_valid;
         prev_stall = frm_valid && !frm_ready;
         prev_data  = frm_data;
         prev_start = frm_start;
         prev_last  = frm_last;
      end
   end

   task automatic send(input logic [7:0] v);
      bit done;
      done = 1'b0;
      in_data  = v;
      in_valid = 1'b1;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      for (int t = 0; t < 3000 && k_frm < target; t++) @(negedge clk);
      check("frame_wait", int'(k_frm >= target), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", int'(frm_valid), 0);
      check("async_rst_data", int'(frm_data), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_log.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int nz;
      int bad;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_log.delete();

      // Silence: 256 x 0x80 gives an all-zero first frame
      for (int i = 0; i < FL; i++) send(8'h80);
      wait_frames(1);
      check("a_out_count", out_log.size(), FL);
      nz = 0;
      foreach (out_log[i]) if (out_log[i] != 0) nz++;
      check("a_nonzero_outputs", nz, 0);
      check("a_frame_count", int'(frame_count), 1);

      // Ramp 0x80, 0x81, ... then one hop, with a 5-cycle stall mid-frame
      do_reset();
      for (int i = 0; i < FL; i++) send(8'(8'h80 + i));
      wait_frames(1);
      check("b_out0", out_log[0], 0);
      check("b_out1", out_log[1], 1);
`ifdef MFCC_PREEMPH_EN
      check("b_out40", out_log[40], 2);
`else
      check("b_out40", out_log[40], 40);
`endif
      for (int i = FL; i < FL + HOP; i++) send(8'(8'h80 + i));
      for (int t = 0; t < 2000 && out_log.size() < FL + 20; t++) @(negedge clk);
      @(posedge clk);
      #1 frm_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 frm_ready = 1'b1;
      wait_frames(2);
      check("b_out_count", out_log.size(), 2 * FL);
`ifdef MFCC_PREEMPH_EN
      check("b_frame2_out0", out_log[FL], -252);
`else
      check("b_frame2_out0", out_log[FL], -128);
`endif
      bad = 0;
      for (int j = 0; j < FL - HOP; j++) if (out_log[FL + j] != out_log[HOP + j]) bad++;
      check("b_overlap_mismatches", bad, 0);
      check("b_frame_count", int'(frame_count), 2);

      // Extremes: 0x00 then 0xFF
      do_reset();
      send(8'h00);
      send(8'hFF);
      for (int i = 2; i < FL; i++) send(8'h80);
      wait_frames(1);
      check("c_out0", out_log[0], -128);
`ifdef MFCC_PREEMPH_EN
      check("c_out1", out_log[1], 251);
      check("c_out2", out_log[2], -124);
`else
      check("c_out1", out_log[1], 127);
      check("c_out2", out_log[2], 0);
`endif

      // Reset mid-fill of frame 2 and mid-emit of a first frame
      do_reset();
      for (int i = 0; i < FL; i++) send(8'(i * 3));
      wait_frames(1);
      for (int i = 0; i < 100; i++) send(8'(i + 7));
      do_reset();
      check("d_count_after_rst", int'(frame_count), 0);
      for (int i = 0; i < FL; i++) send(8'(i ^ 8'h5A));
      repeat (6) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < FL - 1; i++) send(8'(i + 1));
      repeat (4) @(posedge clk);
      #1;
      check("d_count_before_full", int'(frame_count), 0);
      check("d_no_valid_before_full", int'(frm_valid), 0);
      send(8'h10);
      wait_frames(1);
      check("d_frame_count", int'(frame_count), 1);
      check("d_out_count", out_log.size(), FL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mfcc_preemph_framer.md
MFCC_PREEMPH_FRAMER -- requirements
Module: mfcc_preemph_framer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, meaning samples per output frame (power of 2, 4..1024).
REQ-002 SHALL have parameter HOP, default 128, meaning new samples between frame starts (power of 2, 1 <= HOP <= FRAME_LEN).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  8  unsigned audio sample from the file-reader stage.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port frm_data  output  16  signed pre-emphasised sample, two's complement.
REQ-009 SHALL have port frm_valid  output  1  frm_data valid.
REQ-010 SHALL have port frm_ready  input  1  MFCC stage accepts frm_data.
REQ-011 SHALL have port frm_start  output  1  marks first sample of a frame; qualified by frm_valid.
REQ-012 SHALL have port frm_last  output  1  marks last sample of a frame; qualified by frm_valid.
REQ-013 SHALL have port frame_count  output  16  frames fully emitted since reset, wraps 0xFFFF->0.

Function
REQ-014 SHALL accept an input sample on any cycle with in_valid=1 and in_ready=1; SHALL transfer an output sample on any cycle with frm_valid=1 and frm_ready=1.
REQ-015 SHALL convert each accepted sample to signed x = in_data - 128, 9 bits.
REQ-016 SHALL compute y = x - xp + (xp >>> 5): arithmetic shift, 16-bit signed, no saturation. xp is the previous accepted x, reset to 0, persisting across frames.
REQ-017 SHALL store y in a FRAME_LEN-entry circular buffer at the write pointer. The write pointer SHALL wrap modulo FRAME_LEN.
REQ-018 SHALL implement FSM states FILL and EMIT; reset state FILL.
REQ-019 In FILL, in_ready=1 and frm_valid=0. FILL->EMIT on the acceptance completing FRAME_LEN samples (first frame after reset) or HOP samples (each later frame).
REQ-020 In EMIT, in_ready=0. SHALL output FRAME_LEN samples in arrival order, oldest first, starting at the frame base pointer.
REQ-021 EMIT->FILL on the transfer with frm_last=1. The frame base pointer SHALL advance by HOP modulo FRAME_LEN. frame_count SHALL increment in the same cycle.
REQ-022 First frm_valid of a frame SHALL assert exactly 2 cycles after the clock edge that accepted the frame's final input sample.
REQ-023 With frm_ready held 1, SHALL transfer one sample per cycle with no bubbles.
REQ-024 While frm_valid=1 and frm_ready=0, frm_data, frm_start and frm_last SHALL hold stable, and frm_valid SHALL stay 1.
REQ-025 When HOP=FRAME_LEN, frames SHALL be non-overlapping. Otherwise consecutive frames SHALL share FRAME_LEN-HOP samples.
REQ-026 in_valid asserted during EMIT SHALL be ignored, with no acceptance and no xp update.

Reset
REQ-027 On rst=1, asynchronously: state=FILL; write pointer, base pointer, fill counter, read counter, xp and frame_count=0; in_ready=0 during reset.
REQ-028 On rst=1: frm_valid=0, frm_start=0, frm_last=0, frm_data=0.
REQ-029 Buffer contents SHALL NOT require reset.
REQ-030 A reset asserted mid-FILL or mid-EMIT SHALL discard the partial frame. The next frame SHALL require FRAME_LEN fresh samples.
REQ-031 in_ready SHALL be 1 on the first clk edge after rst deasserts.

Configuration
REQ-032 Macro MFCC_PREEMPH_EN: when defined, y per REQ-016. When undefined, y = x sign-extended to 16 bits, and the xp register SHALL be omitted; all timing SHALL be unchanged.

Verification
REQ-033 Reset then 256 samples of 0x80, frm_ready=1 -> 256 outputs of 0x0000; frm_start on output 0, frm_last on output 255; frame_count=1.
REQ-034 Input ramp 0x80,0x81,...: second output -> x=1, xp=0, y=1; with MFCC_PREEMPH_EN undefined -> outputs 0..255 minus 128 offset, sign-extended.
REQ-035 After the first frame, send 128 more samples -> second frame's first 128 outputs equal samples 128..255 of the stream; in_ready=0 throughout each EMIT.
REQ-036 Hold frm_ready=0 for 5 cycles mid-frame -> frm_data stable; no sample lost or duplicated; frm_valid stays 1.
REQ-037 Input 0x00 then 0xFF (with MFCC_PREEMPH_EN defined) -> y = 127 - (-128) + (-4) = 251 = 0x00FB.
REQ-038 Assert rst after 100 samples of frame 2 -> all outputs 0 immediately; next frame_count increment after 256 new samples.
